// File: rtl/seg7_scan_display.sv
// Binary-to-BCD (double dabble) converter driving a multiplexed 7-segment display
// with leading-zero blanking and overflow dashes.
module seg7_scan_display #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NDIG     = 3,
  parameter int unsigned DIV      = 1000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             ovf,
  output logic [6:0]       seg,
  output logic [NDIG-1:0]  an
);

  // Every 3 input bits add at most one decimal digit, so this never truncates.
  localparam int unsigned BD = (((WIDTH + 2) / 3) > NDIG) ? ((WIDTH + 2) / 3) : NDIG;
  localparam int unsigned BW = 4 * BD;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam longint unsigned MAXV = pow10(NDIG) - 64'd1;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'h3F;
      4'd1:    dec7 = 7'h06;
      4'd2:    dec7 = 7'h5B;
      4'd3:    dec7 = 7'h4F;
      4'd4:    dec7 = 7'h66;
      4'd5:    dec7 = 7'h6D;
      4'd6:    dec7 = 7'h7D;
      4'd7:    dec7 = 7'h07;
      4'd8:    dec7 = 7'h7F;
      4'd9:    dec7 = 7'h6F;
      default: dec7 = 7'h00;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic [WIDTH-1:0]       bin_q, bin_nx;
  logic [BW-1:0]          bcd_q, bcd_adj, bcd_nx;
  logic                   ovf_pend_q;
  logic [NDIG-1:0][3:0]   dig_q;
  logic [PW-1:0]          presc_q;
  logic [IW-1:0]          idx_q;
  logic                   last_c, capture_c, step_c, done_c;
  logic                   hi_nz_c;
  logic [6:0]             seg_d;
  logic [NDIG-1:0]        an_d;

  assign last_c = (cnt_q == CW'(WIDTH - 1));
  assign busy   = (state_q == S_CONV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load)   state_d = S_CONV;
      S_CONV:  if (last_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture_c = 1'b0;
    step_c    = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      S_IDLE:  capture_c = load;
      S_CONV: begin
        step_c = 1'b1;
        done_c = last_c;
      end
      default: ;
    endcase
  end

  // One shift-add-3 iteration.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < BD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_nx, bin_nx} = {bcd_adj, bin_q} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf        <= 1'b0;
      dig_q      <= '0;
    end else begin
      if (capture_c) begin
        bin_q      <= value;
        bcd_q      <= '0;
        cnt_q      <= '0;
        ovf_pend_q <= (64'(value) > MAXV);
      end
      if (step_c) begin
        bin_q <= bin_nx;
        bcd_q <= bcd_nx;
        cnt_q <= cnt_q + CW'(1);
      end
      // Display digits only change once the conversion is complete.
      if (done_c) begin
        dig_q <= bcd_nx[4*NDIG-1:0];
        ovf   <= ovf_pend_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    hi_nz_c = 1'b0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if ((k >= 32'(idx_q)) && (dig_q[k] != 4'd0)) hi_nz_c = 1'b1;
    end
    if (ovf)
      seg_d = 7'h40;
    else if ((BLANK_LZ != 0) && (idx_q != '0) && !hi_nz_c)
      seg_d = 7'h00;
    else
      seg_d = dec7(dig_q[idx_q]);
    an_d = ~(NDIG'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'h3F;
      an  <= ~NDIG'(1);
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: three instances (blanking, no blanking,
// two-digit overflow) checked against an arithmetic model via a scoreboard queue.
module tb_seg7_scan_display;

  typedef struct packed {
    logic [2:0][6:0] a;
    logic [2:0][6:0] b;
    logic [1:0][6:0] c;
    logic            a_ovf;
    logic            c_ovf;
  } exp_t;

  logic       clk, rst, load;
  logic [7:0] value;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [2:0] an_a, an_b;
  logic [1:0] an_c;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb[$];
  exp_t cur, nxt;

  seg7_scan_display #(.WIDTH(8), .NDIG(3), .DIV(4), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy_a), .ovf(ovf_a), .seg(seg_a), .an(an_a));
  seg7_scan_display #(.WIDTH(8), .NDIG(3), .DIV(4), .BLANK_LZ(0)) u_b (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy_b), .ovf(ovf_b), .seg(seg_b), .an(an_b));
  seg7_scan_display #(.WIDTH(8), .NDIG(2), .DIV(4), .BLANK_LZ(1)) u_c (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy_c), .ovf(ovf_c), .seg(seg_c), .an(an_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] mseg(input int v, input int nd, input bit blz, input int k);
    int lim, pk;
    lim = 1;
    pk  = 1;
    for (int j = 0; j < nd; j++) lim = lim * 10;
    for (int j = 0; j < k; j++) pk = pk * 10;
    if (v > lim - 1) return 7'h40;
    if (blz && k > 0 && v < pk) return 7'h00;
    return dec((v / pk) % 10);
  endfunction

  function automatic exp_t model(input int v);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.a[k] = mseg(v, 3, 1'b1, k);
      e.b[k] = mseg(v, 3, 1'b0, k);
    end
    for (int k = 0; k < 2; k++) e.c[k] = mseg(v, 2, 1'b1, k);
    e.a_ovf = (v > 999);
    e.c_ovf = (v > 99);
    return e;
  endfunction

  function automatic int idx_of(input logic [2:0] a);
    case (a)
      3'b110:  return 0;
      3'b101:  return 1;
      3'b011:  return 2;
      default: return -1;
    endcase
  endfunction

  // se: expected digit patterns, oe: expected ovf flags (they differ for one cycle).
  task automatic scan_check(input exp_t se, input exp_t oe);
    int ia, ib, ic;
    ia = idx_of(an_a);
    ib = idx_of(an_b);
    ic = idx_of({1'b1, an_c});
    chk("an_a_onehot", 32'(ia >= 0), 32'd1);
    chk("an_b_onehot", 32'(ib >= 0), 32'd1);
    chk("an_c_onehot", 32'(ic >= 0), 32'd1);
    if (ia >= 0) chk("seg_a", 32'(seg_a), 32'(se.a[ia]));
    if (ib >= 0) chk("seg_b", 32'(seg_b), 32'(se.b[ib]));
    if (ic >= 0) chk("seg_c", 32'(seg_c), 32'(se.c[ic]));
    chk("ovf_a", 32'(ovf_a), 32'(oe.a_ovf));
    chk("ovf_b", 32'(ovf_b), 32'(oe.a_ovf));
    chk("ovf_c", 32'(ovf_c), 32'(oe.c_ovf));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_ovf_a"}, 32'(ovf_a), 32'd0);
    chk({tag, "_ovf_c"}, 32'(ovf_c), 32'd0);
    chk({tag, "_an_a"}, 32'(an_a), 32'b110);
    chk({tag, "_an_c"}, 32'(an_c), 32'b10);
    chk({tag, "_seg_a"}, 32'(seg_a), 32'h3F);
    chk({tag, "_seg_b"}, 32'(seg_b), 32'h3F);
    chk({tag, "_seg_c"}, 32'(seg_c), 32'h3F);
  endtask

  // Load v, verify busy width and that the old value stays up, then the new one.
  task automatic conv(input int v, input bit collide);
    int n;
    @(negedge clk);
    load  = 1'b1;
    value = 8'(v);
    sb.push_back(model(v));
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      scan_check(cur, cur);
      chk("busy_c_in_conv", 32'(busy_c), 32'd1);
      if (collide && n == 2) begin
        load  = 1'b1;
        value = 8'd200;
      end else begin
        load = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    load = 1'b0;
    chk("busy_len", 32'(n), 32'd8);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      nxt = sb.pop_front();
      scan_check(cur, nxt);
      cur = nxt;
    end
    repeat (14) begin
      @(negedge clk);
      scan_check(cur, cur);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic scan_order();
    logic [2:0] prev, exp_an;
    int n, i0, ie;
    prev = an_a;
    n = 0;
    @(negedge clk);
    while (an_a === prev && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("scan_edge_found", 32'(n < 20), 32'd1);
    i0 = idx_of(an_a);
    chk("scan_start_valid", 32'(i0 >= 0), 32'd1);
    if (i0 < 0) i0 = 0;
    for (int i = 0; i < 12; i++) begin
      ie = (i0 + i / 4) % 3;
      exp_an = ~(3'(1) << ie);
      chk("scan_an", 32'(an_a), 32'(exp_an));
      chk("scan_seg", 32'(seg_a), 32'(cur.a[ie]));
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = 8'd0;
    cur   = model(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      scan_check(cur, cur);
    end

    // Asynchronous reset asserted mid-cycle, then held.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_check("rst_async");
    repeat (3) begin
      @(negedge clk);
      reset_check("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;

    conv(123, 1'b0);
    scan_order();
    conv(7, 1'b0);
    conv(0, 1'b0);
    conv(255, 1'b0);
    conv(99, 1'b0);
    conv(45, 1'b1);

    // Reset during the fourth conversion cycle discards the partial result.
    @(negedge clk);
    load  = 1'b1;
    value = 8'd45;
    sb.push_back(model(45));
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_check("rst_abort");
    sb.delete();
    cur = model(0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      scan_check(cur, cur);
    end
    conv(45, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
